// File: rtl/uart_pkg.sv
// Shared UART definitions: byte/word widths, pair-assembler state encoding, default timeout
// and the byte-order helper used to build a word from two received bytes.
package uart_pkg;

   localparam int BYTE_W                 = 8;
   localparam int WORD_W                 = 16;
   localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

   typedef enum logic {
      WAIT_FIRST  = 1'b0,
      WAIT_SECOND = 1'b1
   } pair_state_t;

   // lo_first=1 puts the first byte of the pair in the low half of the word.
   function automatic logic [WORD_W-1:0] pack_word(input logic              lo_first,
                                                   input logic [BYTE_W-1:0] first,
                                                   input logic [BYTE_W-1:0] second);
      return lo_first ? {second, first} : {first, second};
   endfunction

endpackage

// File: rtl/uart_timeout_counter.sv
// Cycle counter with synchronous clear; 'reached' is asserted combinationally on the
// increment that hits LIMIT, and the count wraps to 0 on that same edge.
module uart_timeout_counter #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic reached
);

   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count;

   assign reached = inc && (count == CNT_W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr || reached) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_byte_pair_assembler.sv
// Rebuilds 16-bit words from pairs of UART RX bytes into a one-entry valid/ready holding register.
// Define UART_PAIR_TIMEOUT_EN to abandon a half-received pair after TIMEOUT_CYCLES idle cycles.
module uart_byte_pair_assembler
   import uart_pkg::*;
#(
   parameter bit LO_FIRST       = 1'b1,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_done,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              sync_clr,
   output logic [WORD_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              overrun,
   output logic              pair_err,
   output pair_state_t       fsm_state
);

   pair_state_t       state, state_next;
   logic [BYTE_W-1:0] first_byte;
   logic [WORD_W-1:0] word;
   logic              load_first;
   logic              word_done;
   logic              timeout_hit;

   assign fsm_state = state;
   assign word      = pack_word(LO_FIRST, first_byte, rx_data);

`ifdef UART_PAIR_TIMEOUT_EN
   logic to_clr;
   logic to_inc;

   // Counting only happens while a pair is half-received and the line is quiet.
   assign to_clr = (state == WAIT_FIRST) || sync_clr || rx_done;
   assign to_inc = (state == WAIT_SECOND) && !rx_done && !sync_clr;

   uart_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (to_clr),
      .inc     (to_inc),
      .reached (timeout_hit)
   );
`else
   logic cfg_unused;

   assign timeout_hit = 1'b0;
   assign cfg_unused  = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT_FIRST;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load_first = 1'b0;
      word_done  = 1'b0;
      if (sync_clr) begin
         state_next = WAIT_FIRST;
      end else begin
         case (state)
            WAIT_FIRST: begin
               if (rx_done) begin
                  load_first = 1'b1;
                  state_next = WAIT_SECOND;
               end
            end
            WAIT_SECOND: begin
               if (rx_done) begin
                  word_done  = 1'b1;
                  state_next = WAIT_FIRST;
               end else if (timeout_hit) begin
                  state_next = WAIT_FIRST;
               end
            end
            default: state_next = WAIT_FIRST;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_byte <= '0;
      end else if (load_first) begin
         first_byte <= rx_data;
      end
   end

   // A completed word replaces the held one only if the old one leaves on this same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
         pair_err   <= 1'b0;
      end else begin
         overrun  <= 1'b0;
         pair_err <= timeout_hit;
         if (word_done) begin
            if (!dout_valid || dout_ready) begin
               dout       <= word;
               dout_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_byte_pair_assembler.sv
// Bench for uart_byte_pair_assembler: one low-first and one high-first instance share stimulus
// and are compared every cycle against a byte-queue reference model and an accepted-word scoreboard.
module tb_uart_byte_pair_assembler;
   import uart_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_done = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        sync_clr = 1'b0;
   logic        dout_ready = 1'b0;

   logic [15:0] dout_lo, dout_hi;
   logic        valid_lo, valid_hi;
   logic        overrun_lo, overrun_hi;
   logic        err_lo, err_hi;
   pair_state_t state_lo, state_hi;

   // Reference model: bytes of an incomplete pair, the held word per byte order, pulses.
   logic [7:0]  pend_q[$];
   int          idle;
   logic        m_valid;
   logic [15:0] m_word[2];
   logic        m_overrun;
   logic        m_err;
   logic [15:0] exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_byte_pair_assembler #(.LO_FIRST(1'b1), .TIMEOUT_CYCLES(TO)) u_lo (
      .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data), .sync_clr(sync_clr),
      .dout(dout_lo), .dout_valid(valid_lo), .dout_ready(dout_ready),
      .overrun(overrun_lo), .pair_err(err_lo), .fsm_state(state_lo)
   );

   uart_byte_pair_assembler #(.LO_FIRST(1'b0), .TIMEOUT_CYCLES(TO)) u_hi (
      .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data), .sync_clr(sync_clr),
      .dout(dout_hi), .dout_valid(valid_hi), .dout_ready(dout_ready),
      .overrun(overrun_hi), .pair_err(err_hi), .fsm_state(state_hi)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend_q.delete();
      idle      = 0;
      m_valid   = 1'b0;
      m_word[0] = 16'h0000;
      m_word[1] = 16'h0000;
      m_overrun = 1'b0;
      m_err     = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_edge();
      logic [15:0] w_lo, w_hi;
      logic        have_word;
      have_word = 1'b0;
      w_lo      = 16'h0000;
      w_hi      = 16'h0000;
      m_overrun = 1'b0;
      m_err     = 1'b0;
      if (sync_clr) begin
         pend_q.delete();
         idle = 0;
      end else if (rx_done) begin
         if (pend_q.size() == 0) begin
            pend_q.push_back(rx_data);
            idle = 0;
         end else begin
            w_lo      = {rx_data, pend_q[0]};
            w_hi      = {pend_q[0], rx_data};
            have_word = 1'b1;
            pend_q.delete();
         end
      end else if (pend_q.size() != 0) begin
`ifdef UART_PAIR_TIMEOUT_EN
         idle++;
         if (idle == TO) begin
            pend_q.delete();
            idle  = 0;
            m_err = 1'b1;
         end
`endif
      end
      if (have_word) begin
         if (!m_valid || dout_ready) begin
            m_word[0] = w_lo;
            m_word[1] = w_hi;
            m_valid   = 1'b1;
            exp_q.push_back(w_lo);
         end else begin
            m_overrun = 1'b1;
         end
      end else if (m_valid && dout_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_all();
      check_eq("dout_lo", 32'(dout_lo), 32'(m_word[0]));
      check_eq("dout_hi", 32'(dout_hi), 32'(m_word[1]));
      check_eq("valid_lo", 32'(valid_lo), 32'(m_valid));
      check_eq("valid_hi", 32'(valid_hi), 32'(m_valid));
      check_eq("overrun_lo", 32'(overrun_lo), 32'(m_overrun));
      check_eq("overrun_hi", 32'(overrun_hi), 32'(m_overrun));
      check_eq("pair_err_lo", 32'(err_lo), 32'(m_err));
      check_eq("pair_err_hi", 32'(err_hi), 32'(m_err));
      check_eq("state_lo", 32'(state_lo), (pend_q.size() != 0) ? 32'd1 : 32'd0);
   endtask

   // One clock: scoreboard the consumer handshake, advance the model with the edge, then compare.
   task automatic step();
      logic [15:0] exp_w;
      if (rst_n && m_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'd0, 32'd1);
         end else begin
            exp_w = exp_q.pop_front();
            check_eq("sb_accept", 32'(dout_lo), 32'(exp_w));
         end
      end
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      #1;
      compare_all();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      step();
      rx_done = 1'b0;
   endtask

   task automatic drain();
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation watchdog expired");
   end

   initial begin
      int err_cnt;
      model_reset();
      step();
      step();
      check_eq("reset_dout", 32'(dout_lo), 32'h0);
      check_eq("reset_valid", 32'(valid_lo), 32'h0);
      rst_n = 1'b1;
      step();

      // Low byte first: 0x34 then 0x12 -> 0x1234, valid the cycle after the second byte.
      send_byte(8'h34);
      check_eq("t1_valid_after_first", 32'(valid_lo), 32'h0);
      send_byte(8'h12);
      check_eq("t1_dout", 32'(dout_lo), 32'h1234);
      check_eq("t1_valid", 32'(valid_lo), 32'h1);

      // High byte first on the second instance.
      drain();
      send_byte(8'hAB);
      send_byte(8'hCD);
      check_eq("t2_dout_hi", 32'(dout_hi), 32'hABCD);
      check_eq("t2_dout_lo", 32'(dout_lo), 32'hCDAB);

      // Overrun with the register full, then replacement when ready coincides with completion.
      drain();
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'h78);
      send_byte(8'h56);
      check_eq("t3_overrun", 32'(overrun_lo), 32'h1);
      check_eq("t3_dout_kept", 32'(dout_lo), 32'h1234);
      step();
      check_eq("t3_overrun_pulse", 32'(overrun_lo), 32'h0);
      send_byte(8'h78);
      dout_ready = 1'b1;
      send_byte(8'h56);
      dout_ready = 1'b0;
      check_eq("t3_dout_new", 32'(dout_lo), 32'h5678);
      check_eq("t3_valid_kept", 32'(valid_lo), 32'h1);
      check_eq("t3_no_overrun", 32'(overrun_lo), 32'h0);

      // Long gap inside a pair.
      drain();
      send_byte(8'h11);
      err_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         err_cnt += int'(err_lo);
      end
`ifdef UART_PAIR_TIMEOUT_EN
      check_eq("t4_err_pulses", 32'(err_cnt), 32'd1);
      send_byte(8'h22);
      send_byte(8'h33);
      check_eq("t4_dout", 32'(dout_lo), 32'h3322);
`else
      check_eq("t4_err_pulses", 32'(err_cnt), 32'd0);
      send_byte(8'h22);
      check_eq("t4_dout", 32'(dout_lo), 32'h2211);
`endif

      // sync_clr drops the half pair, ignores a coincident byte and leaves the held word alone.
      send_byte(8'h11);
      sync_clr = 1'b1;
      rx_done  = 1'b1;
      rx_data  = 8'h99;
      step();
      sync_clr = 1'b0;
      rx_done  = 1'b0;
      check_eq("t5_valid_kept", 32'(valid_lo), 32'h1);
      check_eq("t5_state", 32'(state_lo), 32'(WAIT_FIRST));
      send_byte(8'h44);
      dout_ready = 1'b1;
      send_byte(8'h33);
      dout_ready = 1'b0;
      check_eq("t5_dout", 32'(dout_lo), 32'h3344);

      // Asynchronous reset mid-pair with a word held.
      send_byte(8'h55);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("t6_dout", 32'(dout_lo), 32'h0);
      check_eq("t6_valid", 32'(valid_lo), 32'h0);
      check_eq("t6_overrun", 32'(overrun_lo), 32'h0);
      check_eq("t6_pair_err", 32'(err_lo), 32'h0);
      check_eq("t6_state", 32'(state_lo), 32'(WAIT_FIRST));
      step();
      step();
      rst_n = 1'b1;
      step();
      send_byte(8'h02);
      send_byte(8'h01);
      check_eq("t6_dout_after", 32'(dout_lo), 32'h0102);

      // Randomized traffic, backpressure and clears.
      for (int i = 0; i < 3000; i++) begin
         rx_done    = ($urandom_range(0, 2) == 0);
         rx_data    = 8'($urandom_range(0, 255));
         dout_ready = 1'($urandom_range(0, 1));
         sync_clr   = ($urandom_range(0, 39) == 0);
         step();
      end
      rx_done    = 1'b0;
      sync_clr   = 1'b0;
      dout_ready = 1'b1;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
